cyt_byp_rd_arbiter: RTL
=======================

# cyt_byp_rd_arbiter

Shares the single Coyote descriptor-bypass read channel (read command out, read-done status back) among N_REQ internal DMA requesters of the ACCL system. Commands are granted round-robin and forwarded through a one-entry output register. The requester index of every issued command is logged in an in-order ID FIFO, and each returning completion status is steered back to the requester at the FIFO head. It sits between the CCLO DMA movers and the shell's bpss_rd_req/bpss_rd_done interfaces; a second instance serves the write channel.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- CMD_W, 96, bypass command payload width
- STS_W, 16, bypass completion status width
- MAX_OUT, 16, maximum outstanding commands, power of two

Ports:
- aclk  in  1  clock; all logic in this domain
- aresetn  in  1  asynchronous active-low reset
- s_cmd_valid  in  N_REQ  per-requester command valid
- s_cmd_ready  out  N_REQ  per-requester command accept
- s_cmd_data  in  N_REQ*CMD_W  commands, requester i at bits [i*CMD_W +: CMD_W]
- m_cmd_valid  out  1  command to shell (bpss_rd_req.valid)
- m_cmd_ready  in  1  shell accept
- m_cmd_data  out  CMD_W  forwarded command
- s_sts_valid  in  1  completion from shell (bpss_rd_done.valid)
- s_sts_ready  out  1  completion accept
- s_sts_data  in  STS_W  completion payload
- m_sts_valid  out  N_REQ  per-requester completion valid, at most one bit set
- m_sts_ready  in  N_REQ  per-requester completion accept
- m_sts_data  out  STS_W  completion payload, shared by all requesters
- outstanding  out  $clog2(MAX_OUT)+1  commands issued and not yet completed
- err_orphan  out  1  sticky flag: completion received with nothing outstanding

## Operation
Command path:
- rr_ptr (log2 N_REQ bits) marks the highest-priority requester.
- Grant goes to the first requester with s_cmd_valid set, searching rr_ptr, rr_ptr+1, … modulo N_REQ.
- Accept condition: s_cmd_ready[g] = grant_valid & (!m_cmd_valid | m_cmd_ready) & (outstanding < MAX_OUT). Every other ready bit is 0.
- On accept:
  - the output register loads s_cmd_data[g] and sets m_cmd_valid;
  - g is pushed into the ID FIFO;
  - rr_ptr becomes (g+1) mod N_REQ.
- m_cmd_valid clears on m_cmd_ready unless a new accept happens in the same cycle. Back-to-back issue sustains one command per cycle.
- m_cmd_data stays stable while m_cmd_valid=1 and m_cmd_ready=0.

Completion path (combinational pass-through):
- Let head be the ID at the FIFO head.
- m_sts_valid[head] = s_sts_valid & !empty; m_sts_data = s_sts_data; s_sts_ready = m_sts_ready[head].
- The ID FIFO pops on the s_sts handshake.
- If the FIFO is empty: s_sts_ready=1, the status is dropped, err_orphan is set. err_orphan clears only on reset.

Outstanding counter:
- outstanding = FIFO occupancy: +1 per accept, −1 per pop.
- A simultaneous accept and pop leaves it unchanged.
- When outstanding = MAX_OUT, new grants are blocked even if a pop occurs in the same cycle (no same-cycle credit bypass).

Reset (asynchronous): m_cmd_valid=0, m_sts_valid=0, s_cmd_ready=0, rr_ptr=0, FIFO empty, outstanding=0, err_orphan=0, m_cmd_data=0. In-flight commands are lost, and completions arriving afterwards are counted as orphans.

## Timing
- Command latency: requester handshake in cycle t gives m_cmd_valid in cycle t+1.
- Completion latency: 0 cycles, s_sts to m_sts.
- Requesters hold valid and data until ready, per AXI-Stream rules. The arbiter never retracts m_cmd_valid.
- Grant is recomputed every cycle. A requester dropping valid before its handshake violates protocol; behaviour is undefined.
- Wrap-around: rr_ptr and the FIFO pointers wrap modulo N_REQ and MAX_OUT. The FIFO uses an extra MSB to distinguish full from empty.

## Structure
- Shared package cyt_byp_pkg: CMD_W/STS_W defaults, typedef req_id_t (logic [2:0]), and the outstanding-count width function.
- Sub-module cyt_byp_id_fifo: synchronous FIFO of req_id_t, depth MAX_OUT, registered head output, async active-low reset.
- The arbiter mask logic stays inline.

## Test plan
- Single requester: requester 2 sends cmd 0xA5 with m_cmd_ready=1 → m_cmd_data=0xA5 one cycle later; status 0x0001 → m_sts_valid=4'b0100; outstanding returns 1→0.
- Fairness: all 4 requesters continuously valid, m_cmd_ready=1 → grant order 0,1,2,3,0,1… and exactly 1 command per cycle.
- Backpressure: m_cmd_ready=0 for 5 cycles → m_cmd_data stable, all s_cmd_ready=0 after the first accept, no FIFO push.
- Credit limit (MAX_OUT=16): 16 issues with no completions → outstanding=16 and all ready=0. One completion plus a pending request in the same cycle → no grant that cycle; grant on the next cycle.
- Out-of-order requesters, in-order status: issue from 3,1,3,0 → completions routed to 3,1,3,0. Hold m_sts_ready[1]=0 → s_sts_ready=0 until it is raised.
- Orphan/reset: completion with FIFO empty → err_orphan=1 and status consumed. Assert aresetn mid-burst → all outputs reach their reset values in the same cycle, and outstanding=0.

Source files
------------

// File: rtl/cyt_byp_pkg.sv
// cyt_byp_pkg: shared defaults, requester id type and counter width for the bypass arbiters
package cyt_byp_pkg;
    localparam int CMD_W_DEF = 96;
    localparam int STS_W_DEF = 16;
    typedef logic [2:0] req_id_t;
    function automatic int cnt_w(input int max_out);
        return $clog2(max_out) + 1;
    endfunction
endpackage

// File: rtl/cyt_byp_rd_arbiter_if.sv
// cyt_byp_rd_arbiter_if: requester-side and shell-side bypass handshakes of the arbiter
interface cyt_byp_rd_arbiter_if import cyt_byp_pkg::*; #(
    parameter int N_REQ = 4,
    parameter int CMD_W = CMD_W_DEF,
    parameter int STS_W = STS_W_DEF,
    parameter int MAX_OUT = 16
);
    logic [N_REQ-1:0] s_cmd_valid;
    logic [N_REQ-1:0] s_cmd_ready;
    logic [N_REQ*CMD_W-1:0] s_cmd_data;
    logic m_cmd_valid;
    logic m_cmd_ready;
    logic [CMD_W-1:0] m_cmd_data;
    logic s_sts_valid;
    logic s_sts_ready;
    logic [STS_W-1:0] s_sts_data;
    logic [N_REQ-1:0] m_sts_valid;
    logic [N_REQ-1:0] m_sts_ready;
    logic [STS_W-1:0] m_sts_data;
    logic [cnt_w(MAX_OUT)-1:0] outstanding;
    logic err_orphan;
    modport master (
        input s_cmd_valid, s_cmd_data, m_cmd_ready, s_sts_valid, s_sts_data, m_sts_ready,
        output s_cmd_ready, m_cmd_valid, m_cmd_data, s_sts_ready, m_sts_valid, m_sts_data,
        output outstanding, err_orphan
    );
    modport slave (
        output s_cmd_valid, s_cmd_data, m_cmd_ready, s_sts_valid, s_sts_data, m_sts_ready,
        input s_cmd_ready, m_cmd_valid, m_cmd_data, s_sts_ready, m_sts_valid, m_sts_data,
        input outstanding, err_orphan
    );
endinterface

// File: rtl/cyt_byp_id_fifo.sv
// cyt_byp_id_fifo: in-order requester id FIFO with a registered head and occupancy count
module cyt_byp_id_fifo import cyt_byp_pkg::*; #(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  req_id_t din,
    input  logic pop,
    output req_id_t head,
    output logic empty,
    output logic full,
    output logic [cnt_w(DEPTH)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    req_id_t mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [AW-1:0] rd_nxt;
    assign count = wr_ptr - rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_nxt = rd_ptr[AW-1:0] + AW'(1);
    always_ff @(posedge clk)
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    // head must already hold the id in the cycle right after its push
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && (empty || (pop && count == (AW+1)'(1)))) head <= din;
            else if (pop) head <= mem[rd_nxt];
        end
endmodule

// File: rtl/cyt_byp_rd_arbiter.sv
// cyt_byp_rd_arbiter: round-robin share of the bypass read channel with in-order status return
module cyt_byp_rd_arbiter import cyt_byp_pkg::*; #(
    parameter int N_REQ = 4,
    parameter int CMD_W = CMD_W_DEF,
    parameter int STS_W = STS_W_DEF,
    parameter int MAX_OUT = 16
) (
    input logic aclk,
    input logic aresetn,
    cyt_byp_rd_arbiter_if.master bus
);
    localparam int PW = $clog2(N_REQ);
    logic [PW-1:0] rr_ptr, gnt;
    logic gnt_v, acc, pop, empty, full;
    req_id_t head;
    logic [N_REQ-1:0] head_oh;
    logic [cnt_w(MAX_OUT)-1:0] cnt;
    // descending scan so the requester closest to rr_ptr wins
    always_comb begin
        gnt_v = 1'b0;
        gnt = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (|(bus.s_cmd_valid & (N_REQ'(1) << ((int'(rr_ptr) + k) % N_REQ)))) begin
                gnt_v = 1'b1;
                gnt = PW'((int'(rr_ptr) + k) % N_REQ);
            end
    end
    assign acc = aresetn & gnt_v & (~bus.m_cmd_valid | bus.m_cmd_ready) & ~full;
    assign bus.s_cmd_ready = acc ? N_REQ'(1) << gnt : '0;
    assign head_oh = N_REQ'(1) << head;
    assign bus.m_sts_valid = (bus.s_sts_valid & ~empty) ? head_oh : '0;
    assign bus.m_sts_data = STS_W'(bus.s_sts_data);
    assign bus.s_sts_ready = empty | (|(bus.m_sts_ready & head_oh));
    assign pop = bus.s_sts_valid & bus.s_sts_ready & ~empty;
    assign bus.outstanding = cnt;
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            rr_ptr <= '0;
            bus.m_cmd_valid <= 1'b0;
            bus.m_cmd_data <= '0;
            bus.err_orphan <= 1'b0;
        end else begin
            if (acc) begin
                bus.m_cmd_valid <= 1'b1;
                bus.m_cmd_data <= bus.s_cmd_data[int'(gnt)*CMD_W +: CMD_W];
                rr_ptr <= (int'(gnt) == N_REQ - 1) ? '0 : gnt + 1'b1;
            end else if (bus.m_cmd_ready) bus.m_cmd_valid <= 1'b0;
            if (bus.s_sts_valid & empty) bus.err_orphan <= 1'b1;
        end
    cyt_byp_id_fifo #(.DEPTH(MAX_OUT)) u_id_fifo (
        .clk(aclk),
        .rst_n(aresetn),
        .push(acc),
        .din(req_id_t'(gnt)),
        .pop(pop),
        .head(head),
        .empty(empty),
        .full(full),
        .count(cnt)
    );
endmodule
